// File: rtl/sd_spi_master_if.sv
// Host-side register interface of the SD SPI master: transfer request, divider,
// chip-select strobe and completion status.
interface sd_spi_master_if #(
    parameter int unsigned DIV_WIDTH = 8
) ();
    logic                 start;
    logic [7:0]           tx_data;
    logic [DIV_WIDTH-1:0] clk_div;
    logic                 cs_we;
    logic [1:0]           cs_value;
    logic                 busy;
    logic                 done;
    logic [7:0]           rx_data;

    modport master (
        output start, tx_data, clk_div, cs_we, cs_value,
        input  busy, done, rx_data
    );

    modport slave (
        input  start, tx_data, clk_div, cs_we, cs_value,
        output busy, done, rx_data
    );
endinterface

// File: rtl/sd_spi_master.sv
// Byte-oriented SPI mode-0 master for the SD/virtual-disk bus: full-duplex byte
// shift with programmable SCK half-period and two active-low chip selects.
module sd_spi_master #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic           bus_clk,
    input  logic           bus_reset_n,
    sd_spi_master_if.slave host,
    output logic [1:0]     sd_cs,
    output logic           sd_clock,
    output logic           sd_di,
    input  logic           sd_do
);
    // One extra bit so that clk_div = all-ones still gives D = 2^DIV_WIDTH.
    localparam int unsigned CW = DIV_WIDTH + 1;

    typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] div_q, div_d, cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
    logic [1:0]    cs_q, cs_d, pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;
    logic          sck_q, sck_d, mosi_q, mosi_d, done_q, done_d;
    logic          busy, phase_end;

    assign busy      = (state_q != StIdle);
    assign phase_end = (cnt_q == div_q - 1'b1);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        rx_data_d  = rx_data_q;
        cs_d       = cs_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (host.start) begin
                    state_d = StLow;
                    div_d   = CW'(host.clk_div) + 1'b1;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                    tx_sr_d = host.tx_data;
                    mosi_d  = host.tx_data[7];
                end
            end
            StLow: begin
                if (phase_end) begin
                    state_d = StHigh;
                    sck_d   = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHigh: begin
                if (phase_end) begin
                    sck_d = 1'b0;
                    cnt_d = '0;
                    if (bit_q != 3'd7) begin
                        state_d = StLow;
                        bit_d   = bit_q + 1'b1;
                        tx_sr_d = {tx_sr_q[6:0], 1'b0};
                        mosi_d  = tx_sr_q[6];
                    end else begin
                        state_d   = StIdle;
                        mosi_d    = 1'b1;
                        rx_data_d = rx_sr_q;
                        done_d    = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // MISO is captured on the edge that opens the last HIGH cycle of each bit.
        if (state_d == StHigh && cnt_d == div_q - 1'b1) begin
            rx_sr_d = {rx_sr_q[6:0], sd_do};
        end

        if (host.cs_we && !busy) begin
            cs_d = host.cs_value;
        end else if (host.cs_we) begin
            pend_d     = host.cs_value;
            pend_vld_d = 1'b1;
        end

        // Deferred select lands together with done; a strobe on that same cycle wins.
        if (done_d) begin
            pend_vld_d = 1'b0;
            if (host.cs_we) begin
                cs_d = host.cs_value;
            end else if (pend_vld_q) begin
                cs_d = pend_q;
            end
        end
    end

    always_ff @(posedge bus_clk or negedge bus_reset_n) begin
        if (!bus_reset_n) begin
            state_q    <= StIdle;
            div_q      <= '0;
            cnt_q      <= '0;
            bit_q      <= 3'd0;
            tx_sr_q    <= 8'h00;
            rx_sr_q    <= 8'h00;
            rx_data_q  <= 8'h00;
            cs_q       <= 2'b00;
            pend_q     <= 2'b00;
            pend_vld_q <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            cs_q       <= cs_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            done_q     <= done_d;
        end
    end

    assign sd_cs        = ~cs_q;
    assign sd_clock     = sck_q;
    assign sd_di        = mosi_q;
    assign host.busy    = busy;
    assign host.done    = done_q;
    assign host.rx_data = rx_data_q;
endmodule
